glitch_sequencer: RTL and testbench
===================================

Name: glitch_sequencer

Overview:
Parametrised successor to the UART-fed glitch controller datapath: a trigger-armed pulse sequencer that also drives the target reset. Configuration is latched on arm. Firing is either from a synchronised external trigger edge (selectable polarity) or immediate. Output is a programmable delay followed by N pulses of programmable width and spacing. Sits between the UART command handler (config/arm/abort source) and the glitch output pin, and replaces the stubbed target-reset tie-off.

Parameters:
DELAY_W, 24, width of delay_i (cycles from fire to first pulse)
WIDTH_W, 12, width of width_i (pulse high time)
COUNT_W, 8, width of num_pulses_i
SPACING_W, 16, width of spacing_i (low time between pulses)
RESET_W, 16, width of reset_len_i (target reset duration)
SYNC_STAGES, 2, trigger synchroniser depth (>=2)

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  asynchronous active-low reset
arm_i  input  1  one-cycle strobe: latch config and start sequence (honoured only in IDLE)
abort_i  input  1  level; forces IDLE from any state, highest priority
mode_i  input  1  0 = wait for external trigger, 1 = immediate fire
trig_edge_i  input  1  0 = rising, 1 = falling trigger edge
reset_first_i  input  1  1 = pulse target reset before arming/firing
delay_i  input  DELAY_W  fire-to-first-pulse delay
width_i  input  WIDTH_W  pulse high cycles (0 treated as 1)
num_pulses_i  input  COUNT_W  pulse count (0 = no pulses)
spacing_i  input  SPACING_W  low cycles between pulses (0 treated as 1)
reset_len_i  input  RESET_W  target reset cycles (0 treated as 1)
trigger_i  input  1  asynchronous external trigger
pulse_o  output  1  glitch pulse, registered
target_reset_o  output  1  target reset, active-high, registered
busy_o  output  1  high in any state except IDLE
armed_o  output  1  high only in ARMED
done_o  output  1  one-cycle strobe on normal completion

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, synchroniser flops 0.
- States: IDLE, TRST, ARMED, DELAY, PULSE, GAP, DONE.
- IDLE: arm_i=1 latches all cfg inputs (including mode and edge). Next state is TRST if reset_first, else ARMED if mode=0, else DELAY. Cfg inputs are ignored outside the arm cycle.
- TRST: target_reset_o high for exactly max(reset_len,1) cycles, then low. Next state is ARMED if mode=0, else DELAY.
- Trigger path: SYNC_STAGES flops; the edge is detected from the last two stages. Edges are acted on only in ARMED and ignored everywhere else. An edge that arrives during TRST is not remembered.
- Fire cycle F: the cycle an edge is detected in ARMED, or the cycle of entry into DELAY when mode=1.
- pulse_o first rises at cycle F+1+delay. With delay=0 it rises at F+1.
- PULSE: pulse_o high for max(width,1) cycles. GAP: pulse_o low for max(spacing,1) cycles. After the last PULSE the FSM goes straight to DONE; there is no trailing GAP.
- num_pulses=0: DELAY elapses with pulse_o never asserted, then DONE.
- DONE: done_o=1 for one cycle, then IDLE. busy_o drops in the cycle after DONE.
- abort_i: next cycle the FSM is in IDLE and pulse_o, target_reset_o, armed_o and busy_o are all 0. done_o is not asserted. abort beats arm in the same cycle.
- arm_i while busy is ignored. No queuing.
- Counters saturate at neither end. They load width-exact values and count down to 1. Full-scale cfg values must run the exact count with no wrap.

Optional Feature:
Macro GLITCH_SEQ_TIMEOUT_EN. When defined, the block adds parameter TIMEOUT_W (default 24), input timeout_i [TIMEOUT_W], and output timeout_o (reset 0). timeout_i is latched on arm. If the FSM stays in ARMED for timeout_i cycles without an edge (0 = never time out), it returns to IDLE, pulses timeout_o for 1 cycle, and does not assert done_o. When undefined, the ports and parameter are absent and ARMED waits indefinitely.

Test Plan:
- mode=1, delay=5, width=3, num=2, spacing=4, arm at cycle A -> pulse_o high A+7..A+9 and A+14..A+16, done_o at A+17, busy_o low at A+18.
- mode=0 rising, delay=0, width=1, num=1 -> pulse_o high exactly SYNC_STAGES+2 cycles after trigger_i rises; a falling edge alone causes no pulse; trig_edge=1 reverses this.
- reset_first=1, reset_len=10, mode=0 -> target_reset_o high 10 cycles. A trigger edge during TRST is ignored. armed_o rises after TRST and the first edge afterwards fires.
- num=0, delay=8, mode=1 -> pulse_o never high, done_o 9 cycles after arm. width=0 and spacing=0 -> 1-cycle pulses with 1-cycle gaps.
- abort_i mid-PULSE -> pulse_o 0 next cycle, IDLE, no done_o. arm_i during PULSE -> ignored, sequence unchanged. rst_n low mid-run -> all outputs 0 immediately.
- With GLITCH_SEQ_TIMEOUT_EN: timeout=20, no trigger -> timeout_o strobe after 20 armed cycles, no done_o. timeout=0 -> stays armed.

Source files
------------

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - trigger-armed glitch pulse sequencer with target-reset control
// Optional ARMED timeout (timeout_i/timeout_o, TIMEOUT_W) is built when GLITCH_SEQ_TIMEOUT_EN is defined.
module glitch_sequencer #(
   parameter int unsigned DELAY_W     = 24,
   parameter int unsigned WIDTH_W     = 12,
   parameter int unsigned COUNT_W     = 8,
   parameter int unsigned SPACING_W   = 16,
   parameter int unsigned RESET_W     = 16,
   parameter int unsigned SYNC_STAGES = 2
`ifdef GLITCH_SEQ_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_W  = 24
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 arm_i,
   input  logic                 abort_i,
   input  logic                 mode_i,
   input  logic                 trig_edge_i,
   input  logic                 reset_first_i,
   input  logic [DELAY_W-1:0]   delay_i,
   input  logic [WIDTH_W-1:0]   width_i,
   input  logic [COUNT_W-1:0]   num_pulses_i,
   input  logic [SPACING_W-1:0] spacing_i,
   input  logic [RESET_W-1:0]   reset_len_i,
   input  logic                 trigger_i,
`ifdef GLITCH_SEQ_TIMEOUT_EN
   input  logic [TIMEOUT_W-1:0] timeout_i,
   output logic                 timeout_o,
`endif
   output logic                 pulse_o,
   output logic                 target_reset_o,
   output logic                 busy_o,
   output logic                 armed_o,
   output logic                 done_o
);

   localparam int unsigned MAX_A = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
   localparam int unsigned MAX_B = (SPACING_W > RESET_W) ? SPACING_W : RESET_W;
`ifdef GLITCH_SEQ_TIMEOUT_EN
   localparam int unsigned MAX_C = TIMEOUT_W;
`else
   localparam int unsigned MAX_C = 1;
`endif
   localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W  = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
   localparam logic [COUNT_W-1:0] PCNT_ONE = COUNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_TRST, S_ARMED, S_DELAY, S_PULSE, S_GAP, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [COUNT_W-1:0]   pcnt_q, pcnt_d;
   logic                 cfg_mode_q, cfg_mode_d;
   logic                 cfg_edge_q, cfg_edge_d;
   logic [DELAY_W-1:0]   cfg_delay_q, cfg_delay_d;
   logic [WIDTH_W-1:0]   cfg_width_q, cfg_width_d;
   logic [COUNT_W-1:0]   cfg_num_q, cfg_num_d;
   logic [SPACING_W-1:0] cfg_spacing_q, cfg_spacing_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 trig_prev_q;
   logic                 edge_q;
   logic                 pulse_q, trst_q, busy_q, armed_q, done_q;
`ifdef GLITCH_SEQ_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] cfg_to_q, cfg_to_d;
   logic                 timeout_q, to_strobe_d;
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pcnt_d        = pcnt_q;
      cfg_mode_d    = cfg_mode_q;
      cfg_edge_d    = cfg_edge_q;
      cfg_delay_d   = cfg_delay_q;
      cfg_width_d   = cfg_width_q;
      cfg_num_d     = cfg_num_q;
      cfg_spacing_d = cfg_spacing_q;
`ifdef GLITCH_SEQ_TIMEOUT_EN
      cfg_to_d      = cfg_to_q;
      to_strobe_d   = 1'b0;
`endif
      if (abort_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm_i) begin
                  cfg_mode_d    = mode_i;
                  cfg_edge_d    = trig_edge_i;
                  cfg_delay_d   = delay_i;
                  cfg_width_d   = width_i;
                  cfg_num_d     = num_pulses_i;
                  cfg_spacing_d = spacing_i;
                  pcnt_d        = num_pulses_i;
`ifdef GLITCH_SEQ_TIMEOUT_EN
                  cfg_to_d      = timeout_i;
`endif
                  if (reset_first_i) begin
                     state_d = S_TRST;
                     cnt_d   = CNT_W'(reset_len_i);
                  end else if (!mode_i) begin
                     state_d = S_ARMED;
`ifdef GLITCH_SEQ_TIMEOUT_EN
                     cnt_d   = CNT_W'(timeout_i);
`endif
                  end else begin
                     state_d = S_DELAY;
                     cnt_d   = CNT_W'(delay_i);
                  end
               end
            end
            S_TRST: begin
               if (cnt_q <= CNT_ONE) begin
                  if (!cfg_mode_q) begin
                     state_d = S_ARMED;
`ifdef GLITCH_SEQ_TIMEOUT_EN
                     cnt_d   = CNT_W'(cfg_to_q);
`endif
                  end else begin
                     state_d = S_DELAY;
                     cnt_d   = CNT_W'(cfg_delay_q);
                  end
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            S_ARMED: begin
               // The fire cycle is spent here, so DELAY only has to cover delay-1 more cycles.
               if (edge_q) begin
                  if (cfg_num_q == '0 && cfg_delay_q <= DELAY_W'(1)) begin
                     state_d = S_DONE;
                  end else if (cfg_num_q != '0 && cfg_delay_q == '0) begin
                     state_d = S_PULSE;
                     cnt_d   = CNT_W'(cfg_width_q);
                  end else begin
                     state_d = S_DELAY;
                     cnt_d   = CNT_W'(cfg_delay_q) - CNT_ONE;
                  end
               end
`ifdef GLITCH_SEQ_TIMEOUT_EN
               else if (cfg_to_q != '0) begin
                  if (cnt_q <= CNT_ONE) begin
                     state_d     = S_IDLE;
                     to_strobe_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q - CNT_ONE;
                  end
               end
`endif
            end
            S_DELAY: begin
               if (cfg_num_q == '0) begin
                  if (cnt_q <= CNT_ONE) state_d = S_DONE;
                  else                  cnt_d   = cnt_q - CNT_ONE;
               end else if (cnt_q == '0) begin
                  state_d = S_PULSE;
                  cnt_d   = CNT_W'(cfg_width_q);
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            S_PULSE: begin
               if (cnt_q <= CNT_ONE) begin
                  if (pcnt_q <= PCNT_ONE) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_GAP;
                     cnt_d   = CNT_W'(cfg_spacing_q);
                     pcnt_d  = pcnt_q - PCNT_ONE;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            S_GAP: begin
               if (cnt_q <= CNT_ONE) begin
                  state_d = S_PULSE;
                  cnt_d   = CNT_W'(cfg_width_q);
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         pcnt_q        <= '0;
         cfg_mode_q    <= 1'b0;
         cfg_edge_q    <= 1'b0;
         cfg_delay_q   <= '0;
         cfg_width_q   <= '0;
         cfg_num_q     <= '0;
         cfg_spacing_q <= '0;
         sync_q        <= '0;
         trig_prev_q   <= 1'b0;
         edge_q        <= 1'b0;
         pulse_q       <= 1'b0;
         trst_q        <= 1'b0;
         busy_q        <= 1'b0;
         armed_q       <= 1'b0;
         done_q        <= 1'b0;
`ifdef GLITCH_SEQ_TIMEOUT_EN
         cfg_to_q      <= '0;
         timeout_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pcnt_q        <= pcnt_d;
         cfg_mode_q    <= cfg_mode_d;
         cfg_edge_q    <= cfg_edge_d;
         cfg_delay_q   <= cfg_delay_d;
         cfg_width_q   <= cfg_width_d;
         cfg_num_q     <= cfg_num_d;
         cfg_spacing_q <= cfg_spacing_d;
         sync_q        <= {sync_q[SYNC_STAGES-2:0], trigger_i};
         trig_prev_q   <= sync_q[SYNC_STAGES-1];
         // Edge is registered so the fire decision sees a clean one-cycle strobe.
         edge_q        <= cfg_edge_d ? (trig_prev_q & ~sync_q[SYNC_STAGES-1])
                                     : (sync_q[SYNC_STAGES-1] & ~trig_prev_q);
         pulse_q       <= (state_d == S_PULSE);
         trst_q        <= (state_d == S_TRST);
         busy_q        <= (state_d != S_IDLE);
         armed_q       <= (state_d == S_ARMED);
         done_q        <= (state_d == S_DONE);
`ifdef GLITCH_SEQ_TIMEOUT_EN
         cfg_to_q      <= cfg_to_d;
         timeout_q     <= to_strobe_d;
`endif
      end
   end

   assign pulse_o        = pulse_q;
   assign target_reset_o = trst_q;
   assign busy_o         = busy_q;
   assign armed_o        = armed_q;
   assign done_o         = done_q;
`ifdef GLITCH_SEQ_TIMEOUT_EN
   assign timeout_o      = timeout_q;
`endif

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - self-checking bench for glitch_sequencer
// Expected traces come from a cycle-indexed timing model of the sequencer's rules.
module tb_glitch_sequencer;
   localparam int S = 2;

   logic clk = 1'b0;
   logic rst_n, arm_i, abort_i, mode_i, trig_edge_i, reset_first_i, trigger_i;
   logic [23:0] delay_i;
   logic [11:0] width_i;
   logic [7:0]  num_pulses_i;
   logic [15:0] spacing_i;
   logic [15:0] reset_len_i;
   logic pulse_o, target_reset_o, busy_o, armed_o, done_o;
`ifdef GLITCH_SEQ_TIMEOUT_EN
   logic [23:0] timeout_i;
   logic        timeout_o;
`endif

   int checks = 0;
   int failures = 0;
   logic [4:0] obs   [0:4199];
   logic [4:0] exp_v [0:4199];
   int c_mode, c_edge, c_rf, c_delay, c_width, c_num, c_spacing, c_rlen, c_timeout;
   int ev_n;
   int ev_t [4];
   logic ev_v [4];
   logic trig_idle;

   always #5 clk = ~clk;

   glitch_sequencer #(.SYNC_STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .abort_i(abort_i), .mode_i(mode_i),
      .trig_edge_i(trig_edge_i), .reset_first_i(reset_first_i), .delay_i(delay_i),
      .width_i(width_i), .num_pulses_i(num_pulses_i), .spacing_i(spacing_i),
      .reset_len_i(reset_len_i), .trigger_i(trigger_i),
`ifdef GLITCH_SEQ_TIMEOUT_EN
      .timeout_i(timeout_i), .timeout_o(timeout_o),
`endif
      .pulse_o(pulse_o), .target_reset_o(target_reset_o), .busy_o(busy_o),
      .armed_o(armed_o), .done_o(done_o)
   );

   task automatic drive_cfg();
      mode_i        = c_mode[0];
      trig_edge_i   = c_edge[0];
      reset_first_i = c_rf[0];
      delay_i       = 24'(c_delay);
      width_i       = 12'(c_width);
      num_pulses_i  = 8'(c_num);
      spacing_i     = 16'(c_spacing);
      reset_len_i   = 16'(c_rlen);
`ifdef GLITCH_SEQ_TIMEOUT_EN
      timeout_i     = 24'(c_timeout);
`endif
   endtask

   task automatic set_cfg(input int mode, input int edg, input int rf, input int dly,
                          input int wid, input int num, input int spc, input int rlen);
      c_mode = mode; c_edge = edg; c_rf = rf; c_delay = dly;
      c_width = wid; c_num = num; c_spacing = spc; c_rlen = rlen; c_timeout = 0;
      ev_n = 0; trig_idle = 1'b0;
   endtask

   // Arms at observation index 0; obs[k] is sampled k clock edges after the arm edge.
   task automatic capture(input int nobs, input int abort_at, input int rearm_at);
      trigger_i = trig_idle; abort_i = 1'b0; arm_i = 1'b0;
      repeat (S + 3) @(negedge clk);
      drive_cfg();
      arm_i = 1'b1;
      obs[0] = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
      for (int k = 1; k <= nobs; k++) begin
         @(negedge clk);
         arm_i   = 1'b0;
         abort_i = (k == abort_at);
         if (k == rearm_at) begin
            arm_i = 1'b1; mode_i = 1'b1; reset_first_i = 1'b1;
            delay_i = '0; width_i = 12'd1; num_pulses_i = 8'd9;
         end
         for (int e = 0; e < ev_n; e++) if (ev_t[e] == k) trigger_i = ev_v[e];
         obs[k] = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
      end
      @(negedge clk) abort_i = 1'b1;
      @(negedge clk) abort_i = 1'b0;
      trigger_i = trig_idle;
   endtask

   // fire_t: index at which the qualifying trigger level change is driven (-1 none).
   task automatic build_expected(input int nobs, input int fire_t, input int abort_at);
      int rl, w, s, entry, f, done_c, start;
      logic p, t, b, a, d;
      rl = (c_rlen == 0) ? 1 : c_rlen;
      w  = (c_width == 0) ? 1 : c_width;
      s  = (c_spacing == 0) ? 1 : c_spacing;
      entry = (c_rf != 0) ? rl + 1 : 1;
      if (c_mode != 0)     f = entry;
      else if (fire_t < 0) f = -1;
      else                 f = fire_t + S + 1;
      start = 0;
      if (f < 0)            done_c = -1;
      else if (c_num > 0) begin
         start  = f + 1 + c_delay;
         done_c = start + c_num * w + (c_num - 1) * s;
      end else              done_c = f + ((c_delay == 0) ? 1 : c_delay);
      for (int k = 0; k <= nobs; k++) begin
         p = 1'b0;
         if (f >= 0 && c_num > 0 && k >= start && k < done_c) p = (((k - start) % (w + s)) < w);
         t = (c_rf != 0) && k >= 1 && k <= rl;
         b = k >= 1 && (done_c < 0 || k <= done_c);
         a = (c_mode == 0) && k >= entry && (f < 0 || k <= f);
         d = (k == done_c);
         exp_v[k] = {p, t, b, a, d};
         if (abort_at >= 0 && k > abort_at) exp_v[k] = 5'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; arm_i = 1'b0; abort_i = 1'b0; trigger_i = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
      drive_cfg();
      repeat (3) @(negedge clk);
      checks++;
      if ({pulse_o, target_reset_o, busy_o, armed_o, done_o} !== 5'b0) begin
         failures++; $display("FAIL reset_held got=%b exp=00000", {pulse_o, target_reset_o, busy_o, armed_o, done_o});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({pulse_o, target_reset_o, busy_o, armed_o, done_o} !== 5'b0) begin
         failures++; $display("FAIL reset_release got=%b exp=00000", {pulse_o, target_reset_o, busy_o, armed_o, done_o});
      end
   endtask

   task automatic test_immediate();
      set_cfg(1, 0, 0, 5, 3, 2, 4, 0);
      capture(22, -1, -1);
      build_expected(22, -1, -1);
      for (int k = 0; k <= 22; k++) begin
         checks++;
         if (obs[k] !== exp_v[k]) begin
            failures++; $display("FAIL immediate cyc=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
         end
      end
      checks++;
      if (obs[6][4] !== 1'b0 || obs[7][4] !== 1'b1 || obs[9][4] !== 1'b1 || obs[10][4] !== 1'b0 ||
          obs[14][4] !== 1'b1 || obs[16][4] !== 1'b1 || obs[17][0] !== 1'b1 || obs[18][2] !== 1'b0) begin
         failures++; $display("FAIL immediate_points p6=%b p7=%b p10=%b p14=%b d17=%b b18=%b exp 0 1 0 1 1 0",
                              obs[6][4], obs[7][4], obs[10][4], obs[14][4], obs[17][0], obs[18][2]);
      end
   endtask

   task automatic test_trigger_edges();
      for (int v = 0; v < 4; v++) begin
         int fire;
         set_cfg(0, v / 2, 0, 0, 1, 1, 0, 0);
         trig_idle = v[0];
         ev_n = 1; ev_t[0] = 4; ev_v[0] = ~trig_idle;
         fire = ((v == 0) || (v == 3)) ? 4 : -1;
         capture(20, -1, -1);
         build_expected(20, fire, -1);
         for (int k = 0; k <= 20; k++) begin
            checks++;
            if (obs[k] !== exp_v[k]) begin
               failures++; $display("FAIL trigger_v%0d cyc=%0d got=%b exp=%b", v, k, obs[k], exp_v[k]);
            end
         end
         checks++;
         if (obs[4 + S + 2][4] !== (fire >= 0)) begin
            failures++; $display("FAIL trigger_latency_v%0d got=%b exp=%b", v, obs[4 + S + 2][4], fire >= 0);
         end
      end
   endtask

   task automatic test_reset_first();
      set_cfg(0, 0, 1, 2, 2, 2, 1, 10);
      ev_n = 3;
      ev_t[0] = 2;  ev_v[0] = 1'b1;
      ev_t[1] = 4;  ev_v[1] = 1'b0;
      ev_t[2] = 14; ev_v[2] = 1'b1;
      capture(40, -1, -1);
      build_expected(40, 14, -1);
      for (int k = 0; k <= 40; k++) begin
         checks++;
         if (obs[k] !== exp_v[k]) begin
            failures++; $display("FAIL reset_first cyc=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
         end
      end
   endtask

   task automatic test_zero_cfg();
      set_cfg(1, 0, 0, 8, 3, 0, 2, 0);
      capture(14, -1, -1);
      build_expected(14, -1, -1);
      for (int k = 0; k <= 14; k++) begin
         checks++;
         if (obs[k] !== exp_v[k]) begin
            failures++; $display("FAIL num_zero cyc=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
         end
      end
      checks++;
      if (obs[9][0] !== 1'b1 || obs[8][0] !== 1'b0) begin
         failures++; $display("FAIL num_zero_done got=%b%b exp=01", obs[8][0], obs[9][0]);
      end
      set_cfg(1, 0, 0, 1, 0, 3, 0, 0);
      capture(15, -1, -1);
      build_expected(15, -1, -1);
      for (int k = 0; k <= 15; k++) begin
         checks++;
         if (obs[k] !== exp_v[k]) begin
            failures++; $display("FAIL width_zero cyc=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
         end
      end
   endtask

   task automatic test_abort_rearm();
      set_cfg(1, 0, 0, 2, 6, 2, 3, 0);
      capture(20, 6, -1);
      build_expected(20, -1, 6);
      for (int k = 0; k <= 20; k++) begin
         checks++;
         if (obs[k] !== exp_v[k]) begin
            failures++; $display("FAIL abort cyc=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
         end
      end
      set_cfg(1, 0, 0, 2, 6, 2, 3, 0);
      capture(30, -1, 5);
      build_expected(30, -1, -1);
      for (int k = 0; k <= 30; k++) begin
         checks++;
         if (obs[k] !== exp_v[k]) begin
            failures++; $display("FAIL rearm_ignored cyc=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
         end
      end
   endtask

   task automatic test_full_scale();
      set_cfg(1, 0, 0, 0, 4095, 1, 0, 0);
      capture(4100, -1, -1);
      build_expected(4100, -1, -1);
      for (int k = 0; k <= 4100; k++) begin
         checks++;
         if (obs[k] !== exp_v[k]) begin
            failures++; $display("FAIL full_width cyc=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
         end
      end
      set_cfg(1, 0, 0, 0, 1, 255, 1, 0);
      capture(515, -1, -1);
      build_expected(515, -1, -1);
      for (int k = 0; k <= 515; k++) begin
         checks++;
         if (obs[k] !== exp_v[k]) begin
            failures++; $display("FAIL full_count cyc=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         int entry, fire, ab;
         set_cfg($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 6),
                 $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 5));
         entry = (c_rf != 0) ? ((c_rlen == 0) ? 1 : c_rlen) + 1 : 1;
         fire = -1;
         if (c_mode == 0) begin
            trig_idle = c_edge[0];
            ev_n = 1; ev_t[0] = entry + $urandom_range(0, 5); ev_v[0] = ~trig_idle;
            fire = ev_t[0];
         end
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : -1;
         capture(80, ab, -1);
         build_expected(80, fire, ab);
         for (int k = 0; k <= 80; k++) begin
            checks++;
            if (obs[k] !== exp_v[k]) begin
               failures++; $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", it, k, obs[k], exp_v[k]);
            end
         end
      end
   endtask

   task automatic test_reset_midrun();
      set_cfg(1, 0, 0, 0, 50, 1, 0, 0);
      abort_i = 1'b0;
      @(negedge clk);
      drive_cfg();
      arm_i = 1'b1;
      @(negedge clk) arm_i = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (pulse_o !== 1'b1 || busy_o !== 1'b1) begin
         failures++; $display("FAIL midrun_active got=%b%b exp=11", pulse_o, busy_o);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pulse_o, target_reset_o, busy_o, armed_o, done_o} !== 5'b0) begin
         failures++; $display("FAIL midrun_reset got=%b exp=00000", {pulse_o, target_reset_o, busy_o, armed_o, done_o});
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({pulse_o, busy_o, done_o} !== 3'b0) begin
         failures++; $display("FAIL midrun_after got=%b exp=000", {pulse_o, busy_o, done_o});
      end
   endtask

`ifdef GLITCH_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      logic to_seen [0:25];
      logic ar_seen [0:25];
      logic dn_any;
      set_cfg(0, 0, 0, 0, 1, 1, 0, 0);
      c_timeout = 20;
      trigger_i = 1'b0;
      repeat (S + 3) @(negedge clk);
      drive_cfg();
      arm_i = 1'b1;
      dn_any = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         arm_i = 1'b0;
         to_seen[k] = timeout_o; ar_seen[k] = armed_o;
         if (done_o) dn_any = 1'b1;
      end
      checks++;
      if (ar_seen[20] !== 1'b1 || ar_seen[21] !== 1'b0 || to_seen[20] !== 1'b0 ||
          to_seen[21] !== 1'b1 || to_seen[22] !== 1'b0 || dn_any !== 1'b0) begin
         failures++; $display("FAIL timeout a20=%b a21=%b t20=%b t21=%b t22=%b done=%b exp 1 0 0 1 0 0",
                              ar_seen[20], ar_seen[21], to_seen[20], to_seen[21], to_seen[22], dn_any);
      end
      c_timeout = 0;
      drive_cfg();
      arm_i = 1'b1;
      @(negedge clk) arm_i = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (armed_o !== 1'b1 || timeout_o !== 1'b0) begin
         failures++; $display("FAIL timeout_zero armed=%b to=%b exp 1 0", armed_o, timeout_o);
      end
      @(negedge clk) abort_i = 1'b1;
      @(negedge clk) abort_i = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_immediate();
      test_trigger_edges();
      test_reset_first();
      test_zero_cfg();
      test_abort_rearm();
      test_full_scale();
      test_random();
      test_reset_midrun();
`ifdef GLITCH_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
